// File: rtl/fetch_stage_if.sv
// fetch_stage_if -- pipeline-side signal bundle of the fetch stage.
//   master : the fetch stage (drives IMEM_ADDR and the IF/ID outputs)
//   slave  : hazard unit / branch unit / instruction memory / decode
// Signals:
//   STALL_F, STALL_D, FLUSH_D, BRANCH_TAKEN, BRANCH_TARGET : control in
//   IMEM_ADDR / IMEM_RD                                    : imem port
//   INSTR_D, PC_D, PCPLUS4_D, VALID_D, FAULT_D             : IF/ID register
//   FETCH_COUNT                                            : valid-load count
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  STALL_F;
    logic                  STALL_D;
    logic                  FLUSH_D;
    logic                  BRANCH_TAKEN;
    logic [ADDR_WIDTH-1:0] BRANCH_TARGET;
    logic [ADDR_WIDTH-1:0] IMEM_ADDR;
    logic [DATA_WIDTH-1:0] IMEM_RD;
    logic [DATA_WIDTH-1:0] INSTR_D;
    logic [ADDR_WIDTH-1:0] PC_D;
    logic [ADDR_WIDTH-1:0] PCPLUS4_D;
    logic                  VALID_D;
    logic                  FAULT_D;
    logic [31:0]           FETCH_COUNT;

    modport master (
        input  STALL_F, STALL_D, FLUSH_D, BRANCH_TAKEN, BRANCH_TARGET, IMEM_RD,
        output IMEM_ADDR, INSTR_D, PC_D, PCPLUS4_D, VALID_D, FAULT_D, FETCH_COUNT
    );

    modport slave (
        output STALL_F, STALL_D, FLUSH_D, BRANCH_TAKEN, BRANCH_TARGET, IMEM_RD,
        input  IMEM_ADDR, INSTR_D, PC_D, PCPLUS4_D, VALID_D, FAULT_D, FETCH_COUNT
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage -- PC register, instruction fetch and IF/ID pipeline register.
// Ports:
//   CLK   : rising-edge clock
//   RESET : synchronous active-high reset
//   bus   : fetch_stage_if master (control inputs, imem port, IF/ID outputs)
// The PC register drives IMEM_ADDR directly. Each cycle the IF/ID register
// is cleared, held, squash-loaded, fault-loaded or normally loaded, in that
// priority order; FETCH_COUNT counts normal loads and saturates.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    IMEM_BYTES = 24,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic          CLK,
    input  logic          RESET,
    fetch_stage_if.master bus
);
    // Highest PC at which a full word still fits inside the memory.
    localparam logic [ADDR_WIDTH-1:0] IMEM_LAST = ADDR_WIDTH'(IMEM_BYTES - 4);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_dec_q, pc_dec_d;
    logic [ADDR_WIDTH-1:0] pcplus4_q, pcplus4_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    logic [31:0]           count_q, count_d;

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  fetch_fault;

    always_comb begin
        pc_plus4    = pc_q + ADDR_WIDTH'(4);
        fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q > IMEM_LAST);

        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_dec_d  = pc_dec_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        count_d   = count_q;

        // A redirect wins over a front-end stall.
        if (bus.BRANCH_TAKEN) begin
            pc_d = bus.BRANCH_TARGET;
        end else if (!bus.STALL_F) begin
            pc_d = pc_plus4;
        end

        if (bus.FLUSH_D) begin
            instr_d   = NOP_WORD;
            pc_dec_d  = '0;
            pcplus4_d = '0;
            valid_d   = 1'b0;
            fault_d   = 1'b0;
        end else if (!bus.STALL_D) begin
            pc_dec_d  = pc_q;
            pcplus4_d = pc_plus4;
            if (bus.BRANCH_TAKEN) begin
                // Word fetched during the redirect cycle is wrong-path.
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                fault_d = 1'b0;
            end else if (fetch_fault) begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end else begin
                instr_d = bus.IMEM_RD;
                valid_d = 1'b1;
                fault_d = 1'b0;
                if (count_q != 32'hFFFF_FFFF) begin
                    count_d = count_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP_WORD;
            pc_dec_q  <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_dec_q  <= pc_dec_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            count_q   <= count_d;
        end
    end

    assign bus.IMEM_ADDR   = pc_q;
    assign bus.INSTR_D     = instr_q;
    assign bus.PC_D        = pc_dec_q;
    assign bus.PCPLUS4_D   = pcplus4_q;
    assign bus.VALID_D     = valid_q;
    assign bus.FAULT_D     = fault_q;
    assign bus.FETCH_COUNT = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    fetch_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_stage #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0),
        .IMEM_BYTES(24), .NOP_WORD(32'h0)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Instruction memory contents: W_k at byte address 4k; anything outside
    // the 24-byte image returns a recognisable garbage word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd24 && a[1:0] == 2'b00) return 32'hC0DE_0000 + a;
        return 32'hBAD0_0000 ^ a;
    endfunction

    function automatic logic [31:0] w(input int k);
        return 32'hC0DE_0000 + 32'(4 * k);
    endfunction

    always_comb bus.IMEM_RD = mem_word(bus.IMEM_ADDR);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pcp4;
        logic        valid;
        logic        fault;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;   // reference state after the last edge
    int n_assert = 0;
    int n_fail   = 0;
    int step_no  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict the post-edge state, then compare.
    task automatic step(input logic rst, input logic stf, input logic std,
                        input logic fl, input logic bt, input logic [31:0] tgt);
        exp_t e;
        exp_t got;
        logic flt;
        @(negedge CLK);
        RESET             = rst;
        bus.STALL_F       = stf;
        bus.STALL_D       = std;
        bus.FLUSH_D       = fl;
        bus.BRANCH_TAKEN  = bt;
        bus.BRANCH_TARGET = tgt;
        e   = m;
        flt = (m.pc[1:0] != 2'b00) || (m.pc > 32'd20);
        if (rst) begin
            e.pc = 32'h0; e.instr = NOP; e.pcd = 0; e.pcp4 = 0;
            e.valid = 0; e.fault = 0; e.cnt = 0;
        end else begin
            e.pc = bt ? tgt : (stf ? m.pc : m.pc + 32'd4);
            if (fl) begin
                e.instr = NOP; e.pcd = 0; e.pcp4 = 0; e.valid = 0; e.fault = 0;
            end else if (!std) begin
                e.pcd  = m.pc;
                e.pcp4 = m.pc + 32'd4;
                if (bt) begin
                    e.instr = NOP; e.valid = 0; e.fault = 0;
                end else if (flt) begin
                    e.instr = NOP; e.valid = 0; e.fault = 1;
                end else begin
                    e.instr = mem_word(m.pc); e.valid = 1; e.fault = 0;
                    if (m.cnt != 32'hFFFF_FFFF) e.cnt = m.cnt + 1;
                end
            end
        end
        sb.push_back(e);
        @(posedge CLK);
        #1;
        step_no++;
        got = sb.pop_front();
        chk("imem_addr",   bus.IMEM_ADDR,   got.pc);
        chk("instr_d",     bus.INSTR_D,     got.instr);
        chk("pc_d",        bus.PC_D,        got.pcd);
        chk("pcplus4_d",   bus.PCPLUS4_D,   got.pcp4);
        chk("valid_d",     32'(bus.VALID_D), 32'(got.valid));
        chk("fault_d",     32'(bus.FAULT_D), 32'(got.fault));
        chk("fetch_count", bus.FETCH_COUNT, got.cnt);
        m = got;
    endtask

    task automatic go(); step(0, 0, 0, 0, 0, 32'h0); endtask

    initial begin
        RESET = 1; bus.STALL_F = 0; bus.STALL_D = 0; bus.FLUSH_D = 0;
        bus.BRANCH_TAKEN = 0; bus.BRANCH_TARGET = 0;
        m = '{pc: 32'hFFFF_FFFF, instr: 0, pcd: 0, pcp4: 0, valid: 0, fault: 0, cnt: 0};

        // Reset, with noisy inputs that must be ignored.
        step(1, 1, 0, 0, 1, 32'h40);
        step(1, 0, 0, 0, 0, 32'h0);
        chk("rst_addr",  bus.IMEM_ADDR, 32'h0);
        chk("rst_valid", 32'(bus.VALID_D), 32'h0);
        chk("rst_instr", bus.INSTR_D, NOP);

        // Sequential fetch W0..W5.
        for (int k = 0; k < 6; k++) begin
            go();
            chk("seq_instr", bus.INSTR_D, w(k));
            chk("seq_addr",  bus.IMEM_ADDR, 32'(4 * (k + 1)));
        end
        chk("seq_count", bus.FETCH_COUNT, 32'd6);
        go();                                  // PC=24 is out of range
        chk("oor_fault", 32'(bus.FAULT_D), 32'h1);
        chk("oor_count", bus.FETCH_COUNT, 32'd6);

        // Stall at PC=8.
        step(1, 0, 0, 0, 0, 0);
        go(); go();
        chk("pre_stall_addr", bus.IMEM_ADDR, 32'd8);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        chk("stall_addr",  bus.IMEM_ADDR, 32'd8);
        chk("stall_instr", bus.INSTR_D, w(1));
        chk("stall_count", bus.FETCH_COUNT, 32'd2);
        go();
        chk("unstall_instr", bus.INSTR_D, w(2));

        // Branch at PC=12 to 4.
        step(0, 0, 0, 0, 1, 32'd4);
        chk("br_addr",  bus.IMEM_ADDR, 32'd4);
        chk("br_valid", 32'(bus.VALID_D), 32'h0);
        chk("br_instr", bus.INSTR_D, NOP);
        go();
        chk("br_w1",    bus.INSTR_D, w(1));
        chk("br_w1_v",  32'(bus.VALID_D), 32'h1);

        // Branch overrides stall.
        step(0, 1, 0, 0, 1, 32'd16);
        chk("brst_addr", bus.IMEM_ADDR, 32'd16);
        step(0, 1, 1, 0, 1, 32'd0);
        chk("brst_hold_addr", bus.IMEM_ADDR, 32'd0);
        chk("brst_hold_pcd",  bus.PC_D, 32'd8);
        step(0, 1, 0, 0, 0, 0);                 // same-PC reload
        step(0, 1, 0, 0, 0, 0);
        chk("reload_pcd", bus.PC_D, 32'd0);

        // Faulting targets.
        step(0, 0, 0, 0, 1, 32'd22);
        go();
        chk("f22_fault", 32'(bus.FAULT_D), 32'h1);
        chk("f22_valid", 32'(bus.VALID_D), 32'h0);
        go();
        chk("f26_fault", 32'(bus.FAULT_D), 32'h1);
        chk("f26_pcd",   bus.PC_D, 32'd26);
        step(0, 0, 0, 0, 1, 32'd20);
        go();
        chk("f20_w5", bus.INSTR_D, w(5));
        chk("f20_v",  32'(bus.VALID_D), 32'h1);
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        go();                                   // PC+4 wraps to 0
        chk("wrap_addr",  bus.IMEM_ADDR, 32'h0);
        chk("wrap_pcp4",  bus.PCPLUS4_D, 32'h0);
        chk("wrap_fault", 32'(bus.FAULT_D), 32'h1);

        // Flush with stall, then reset mid-redirect.
        go();
        step(0, 0, 1, 1, 0, 0);
        chk("flush_valid", 32'(bus.VALID_D), 32'h0);
        chk("flush_pcd",   bus.PC_D, 32'h0);
        step(1, 1, 1, 0, 1, 32'd12);
        chk("midrst_addr",  bus.IMEM_ADDR, 32'h0);
        chk("midrst_count", bus.FETCH_COUNT, 32'h0);

        // Randomised traffic against the scoreboard model.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 4) == 0), 32'($urandom_range(0, 14)) * 32'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
